imem_boot_loader: RTL
=====================

Name: imem_boot_loader

Overview:
Upstream feeder for the CPU. Takes a byte stream from a host link, frames it into 32-bit instruction words and writes them into instruction memory (the CPU's im.mem array) through a single write port. Holds the CPU in reset while a program is loading. Releases the CPU only after a valid image is written and its checksum matches. Replaces $readmemh preloading, so the same image path works on hardware.

Parameters:
ADDR_WIDTH, 10, instruction-memory word-address width; maximum image is 2^ADDR_WIDTH words.
RESET_CYCLES, 4, number of cycles cpu_reset stays high after a good load, before release (range 1..255).

Ports:
clk  input  1  system clock; all state changes on the rising edge.
reset  input  1  asynchronous, active-low reset.
start  input  1  one-cycle request to begin a load.
byte_in  input  8  stream data byte.
byte_valid  input  1  byte_in holds a valid byte.
byte_ready  output  1  loader can accept a byte this cycle.
imem_we  output  1  instruction-memory write enable.
imem_addr  output  ADDR_WIDTH  word address for the write.
imem_wdata  output  32  word to write.
cpu_reset  output  1  active-high reset driven to the CPU's reset port.
done  output  1  image loaded and CPU released.
error  output  1  load failed (length too large or checksum mismatch).

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; byte_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_reset=1, done=0, error=0. Memory contents are not cleared.
- A byte is accepted only on a rising edge where byte_valid=1 and byte_ready=1. byte_ready is a registered function of state: 1 in LEN_HI, LEN_LO, DATA and CSUM; 0 otherwise.
- Frame format: 16-bit word count N, MSB first; then 4N data bytes, each word MSB first; then 1 checksum byte equal to the XOR of all data bytes. The length bytes are excluded from the checksum.
- State machine:
  - IDLE: when start=1, go to LEN_HI. Clear the word index, byte-lane counter and running XOR; hold cpu_reset=1.
  - LEN_HI -> LEN_LO on an accepted byte.
  - LEN_LO, on an accepted byte:
    - N > 2^ADDR_WIDTH -> ERROR.
    - N = 0 -> CSUM.
    - otherwise -> DATA.
  - DATA: shift each accepted byte into the word register. On the 4th byte of a word, the next cycle has imem_we=1 for exactly one cycle, with imem_addr = word index and imem_wdata = the assembled word. The word index then increments.
    - byte_ready stays 1 during the write cycle; a 4-byte gap is guaranteed, so there is no hazard.
    - After the Nth word's 4th byte -> CSUM.
  - CSUM, on an accepted byte: match -> BOOT; mismatch -> ERROR.
  - BOOT: cpu_reset=1 for RESET_CYCLES cycles, then cpu_reset=0 and done=1 in the same cycle -> RUN.
  - RUN: hold done=1, cpu_reset=0.
  - ERROR: error=1, cpu_reset=1, done=0.
- start is honoured in IDLE, RUN and ERROR only; it is ignored in all other states.
  - start in RUN or ERROR: the next cycle has cpu_reset=1 and done=0, error=0; state -> LEN_HI.
- imem_we is never asserted outside DATA word completion. At most N writes per load, at addresses 0..N-1 in order.
- Reset asserted mid-load: immediate return to reset values. Words already written remain in memory; a fresh start reloads cleanly.
- imem_addr and imem_wdata hold their last values when imem_we=0.

Test Plan:
1. start; stream 00 02 20 08 00 05 20 09 00 0A 0E with byte_valid held 1 -> imem_we pulses twice: addr 0 with 0x20080005, then addr 1 with 0x2009000A. Then cpu_reset falls exactly RESET_CYCLES cycles after the CSUM byte is accepted, done=1, error=0. The CPU then fetches 0x20080005 at pc 0.
2. Same stream but checksum 0F -> both writes occur, error=1, done=0, cpu_reset stays 1 indefinitely. A new start followed by the correct stream recovers to done=1.
3. start; stream 00 00 00 -> no imem_we pulses, done=1. Stream 00 00 01 instead -> error=1.
4. Scenario 1 with byte_valid toggling 1/0 every cycle, plus a 7-cycle gap mid-word -> identical writes and done. A byte presented while byte_ready=0 is never consumed.
5. ADDR_WIDTH=10; stream 04 01 -> error=1 immediately after LEN_LO, zero writes, byte_ready=0.
6. Drop reset to 0 after the 5th data byte of scenario 1 -> all outputs at reset values within the same cycle. Releasing reset and rerunning scenario 1 yields done=1. A start pulse injected during DATA is ignored: the write count and addresses are unchanged.

Source files
------------

// File: rtl/imem_boot_loader_if.sv
// Host-link / instruction-memory bus for imem_boot_loader.
//   slave  : loader side. Takes start/byte stream, drives memory write port
//            and CPU control (byte_ready, imem_*, cpu_reset, done, error).
//   master : host/memory side, the mirror image.
interface imem_boot_loader_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  start;
  logic [7:0]            byte_in;
  logic                  byte_valid;
  logic                  byte_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;
  logic                  cpu_reset;
  logic                  done;
  logic                  error;

  modport slave (
    input  start, byte_in, byte_valid,
    output byte_ready, imem_we, imem_addr, imem_wdata, cpu_reset, done, error
  );

  modport master (
    output start, byte_in, byte_valid,
    input  byte_ready, imem_we, imem_addr, imem_wdata, cpu_reset, done, error
  );
endinterface

// File: rtl/imem_boot_loader.sv
// Boot loader: frames a host byte stream into 32-bit words, writes them into
// instruction memory and holds the CPU in reset until a checksummed image is in.
// Frame: N[15:8], N[7:0], 4N data bytes (MSB first per word), XOR of data bytes.
// Ports:
//   clk   - system clock, rising edge
//   reset - asynchronous active-low reset
//   bus   - imem_boot_loader_if.slave (stream in, memory write port, CPU ctrl)
module imem_boot_loader #(
  parameter int ADDR_WIDTH   = 10,
  parameter int RESET_CYCLES = 4
) (
  input logic                clk,
  input logic                reset,
  imem_boot_loader_if.slave  bus
);
  localparam int LW = ADDR_WIDTH + 1;  // holds a word count up to 2^ADDR_WIDTH

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LEN_HI = 3'd1;
  localparam logic [2:0] LEN_LO = 3'd2;
  localparam logic [2:0] DATA   = 3'd3;
  localparam logic [2:0] CSUM   = 3'd4;
  localparam logic [2:0] BOOT   = 3'd5;
  localparam logic [2:0] RUN    = 3'd6;
  localparam logic [2:0] ERROR  = 3'd7;

  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_WIDTH;
  localparam logic [7:0]  BOOT_LAST = 8'(RESET_CYCLES - 1);

  logic [2:0]            state_q, state_d;
  logic [7:0]            len_hi_q, len_hi_d;
  logic [LW-1:0]         len_q, len_d;
  logic [LW-1:0]         widx_q, widx_d;
  logic [1:0]            lane_q, lane_d;
  logic [31:0]           word_q, word_d;
  logic [7:0]            xor_q, xor_d;
  logic [7:0]            bcnt_q, bcnt_d;
  logic                  ready_q, ready_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  cpu_rst_q, cpu_rst_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic        acc;
  logic [15:0] n16;
  logic [LW-1:0] widx_inc;

  assign acc      = bus.byte_valid & ready_q;
  assign n16      = {len_hi_q, bus.byte_in};
  assign widx_inc = widx_q + LW'(1);

  always_comb begin
    state_d  = state_q;
    len_hi_d = len_hi_q;
    len_d    = len_q;
    widx_d   = widx_q;
    lane_d   = lane_q;
    word_d   = word_q;
    xor_d    = xor_q;
    bcnt_d   = bcnt_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    case (state_q)
      IDLE, RUN, ERROR: begin
        if (bus.start) begin
          state_d = LEN_HI;
          widx_d  = '0;
          lane_d  = '0;
          xor_d   = '0;
        end
      end
      LEN_HI: if (acc) begin
        len_hi_d = bus.byte_in;
        state_d  = LEN_LO;
      end
      LEN_LO: if (acc) begin
        len_d = n16[ADDR_WIDTH:0];
        if ({1'b0, n16} > MAX_WORDS) state_d = ERROR;
        else if (n16 == 16'd0)       state_d = CSUM;
        else                         state_d = DATA;
      end
      DATA: if (acc) begin
        word_d = {word_q[23:0], bus.byte_in};
        xor_d  = xor_q ^ bus.byte_in;
        lane_d = lane_q + 2'd1;
        if (lane_q == 2'd3) begin
          // write goes out next cycle; index advances with it
          we_d    = 1'b1;
          addr_d  = widx_q[ADDR_WIDTH-1:0];
          wdata_d = {word_q[23:0], bus.byte_in};
          widx_d  = widx_inc;
          if (widx_inc == len_q) state_d = CSUM;
        end
      end
      CSUM: if (acc) begin
        bcnt_d  = '0;
        state_d = (bus.byte_in == xor_q) ? BOOT : ERROR;
      end
      BOOT: begin
        if (bcnt_q == BOOT_LAST) state_d = RUN;
        else                     bcnt_d  = bcnt_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Status outputs are registered decodes of the next state, so they line up
  // exactly with the state they describe.
  always_comb begin
    ready_d   = (state_d == LEN_HI) || (state_d == LEN_LO) ||
                (state_d == DATA)   || (state_d == CSUM);
    cpu_rst_d = (state_d != RUN);
    done_d    = (state_d == RUN);
    err_d     = (state_d == ERROR);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      len_hi_q  <= '0;
      len_q     <= '0;
      widx_q    <= '0;
      lane_q    <= '0;
      word_q    <= '0;
      xor_q     <= '0;
      bcnt_q    <= '0;
      ready_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cpu_rst_q <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_hi_q  <= len_hi_d;
      len_q     <= len_d;
      widx_q    <= widx_d;
      lane_q    <= lane_d;
      word_q    <= word_d;
      xor_q     <= xor_d;
      bcnt_q    <= bcnt_d;
      ready_q   <= ready_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cpu_rst_q <= cpu_rst_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign bus.byte_ready = ready_q;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign bus.cpu_reset  = cpu_rst_q;
  assign bus.done       = done_q;
  assign bus.error      = err_q;
endmodule
